// File: rtl/axi2apb_apb_ctrl_pkg.sv
// Shared definitions for the AXI-to-APB bridge: sequencer state encoding,
// AXI response codes and default bus widths.
package def_axi2apb;

   localparam int DEF_ADDR_BITS = 32;
   localparam int DEF_DATA_BITS = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_e;

   localparam logic [1:0] RESP_OK     = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi2apb_rr_arb2.sv
// Two-requester round-robin arbiter (read vs. write). Grants only while enabled;
// on contention the side that did not win last time gets the grant.
module axi2apb_rr_arb2 (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic req_rd,
   input  logic req_wr,
   output logic grant_rd,
   output logic grant_wr
);

   logic last_wr;

   assign grant_rd = en & req_rd & (~req_wr | last_wr);
   assign grant_wr = en & req_wr & (~req_rd | ~last_wr);

   // Starts as "write won last" so the first contention goes to read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_wr <= 1'b1;
      end else if (grant_rd | grant_wr) begin
         last_wr <= grant_wr;
      end
   end

endmodule

// File: rtl/axi2apb_apb_ctrl.sv
// APB master sequencer: picks a read or write command, runs one APB3 SETUP/ACCESS
// transfer and holds the bus in RESP until the matching response block finishes.
module axi2apb_apb_ctrl
   import def_axi2apb::*;
#(
   parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS,
   parameter int unsigned DATA_BITS   = DEF_DATA_BITS,
   parameter int unsigned TIMEOUT_CYC = 256,
   parameter int unsigned CNT_BITS    = 9
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 rd_cmd_valid,
   input  logic [ADDR_BITS-1:0] rd_cmd_addr,
   input  logic                 rd_cmd_err,
   output logic                 rd_cmd_ready,
   input  logic                 wr_cmd_valid,
   input  logic [ADDR_BITS-1:0] wr_cmd_addr,
   input  logic                 wr_cmd_err,
   input  logic                 wdata_valid,
   input  logic [DATA_BITS-1:0] wdata,
   output logic                 wr_cmd_ready,
   input  logic                 finish_rd,
   input  logic                 finish_wr,
   output logic                 psel,
   output logic                 penable,
   output logic                 pwrite,
   output logic [ADDR_BITS-1:0] paddr,
   output logic [DATA_BITS-1:0] pwdata,
   input  logic                 pready,
   input  logic                 pslverr,
   output logic                 apb_timeout,
   output logic                 resp_err
);

   localparam logic [CNT_BITS-1:0] TO_LAST =
      CNT_BITS'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);

   apb_state_e          state, state_nxt;
   logic                grant_rd, grant_wr;
   logic                timeout_hit;
   logic                finish_cur;
   logic [CNT_BITS-1:0] to_cnt;

   axi2apb_rr_arb2 u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (state == ST_IDLE),
      .req_rd   (rd_cmd_valid),
      .req_wr   (wr_cmd_valid & wdata_valid),
      .grant_rd (grant_rd),
      .grant_wr (grant_wr)
   );

   assign rd_cmd_ready = grant_rd;
   assign wr_cmd_ready = grant_wr;
   assign psel         = (state == ST_SETUP) || (state == ST_ACCESS);
   assign penable      = (state == ST_ACCESS);

   // to_cnt holds the number of ACCESS cycles already spent without pready.
   assign timeout_hit  = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
   // pwrite doubles as the direction of the transfer in flight.
   assign finish_cur   = pwrite ? finish_wr : finish_rd;

   always_comb begin
      state_nxt   = state;
      apb_timeout = 1'b0;
      case (state)
         ST_IDLE: begin
            if (grant_rd) begin
               state_nxt = rd_cmd_err ? ST_RESP : ST_SETUP;
            end else if (grant_wr) begin
               state_nxt = wr_cmd_err ? ST_RESP : ST_SETUP;
            end
         end
         ST_SETUP: state_nxt = ST_ACCESS;
         ST_ACCESS: begin
            if (pready) begin
               state_nxt = ST_RESP;
            end else if (timeout_hit) begin
               state_nxt   = ST_RESP;
               apb_timeout = 1'b1;
            end
         end
         ST_RESP: begin
            if (finish_cur) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         paddr  <= '0;
         pwdata <= '0;
         pwrite <= 1'b0;
      end else if (grant_rd) begin
         paddr  <= rd_cmd_addr;
         pwrite <= 1'b0;
      end else if (grant_wr) begin
         paddr  <= wr_cmd_addr;
         pwdata <= wdata;
         pwrite <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt   <= '0;
         resp_err <= 1'b0;
      end else begin
         if (state == ST_SETUP) begin
            to_cnt <= '0;
         end else if ((state == ST_ACCESS) && !pready) begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (state == ST_ACCESS) begin
            if (pready) begin
               resp_err <= pslverr;
            end else if (timeout_hit) begin
               resp_err <= 1'b1;
            end
         end else if ((state == ST_RESP) && finish_cur) begin
            resp_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axi2apb_apb_ctrl.sv
// Directed bench for axi2apb_apb_ctrl with a 4-cycle ACCESS timeout.
module tb_axi2apb_apb_ctrl;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rd_cmd_valid = 1'b0, rd_cmd_err = 1'b0, rd_cmd_ready;
   logic [31:0] rd_cmd_addr = '0;
   logic        wr_cmd_valid = 1'b0, wr_cmd_err = 1'b0, wdata_valid = 1'b0, wr_cmd_ready;
   logic [31:0] wr_cmd_addr = '0, wdata = '0;
   logic        finish_rd = 1'b0, finish_wr = 1'b0;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic        apb_timeout, resp_err;

   int n_checks = 0;
   int n_errors = 0;
   int n_gr;

   axi2apb_apb_ctrl #(
      .ADDR_BITS(32), .DATA_BITS(32), .TIMEOUT_CYC(4), .CNT_BITS(3)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .rd_cmd_valid(rd_cmd_valid), .rd_cmd_addr(rd_cmd_addr), .rd_cmd_err(rd_cmd_err),
      .rd_cmd_ready(rd_cmd_ready),
      .wr_cmd_valid(wr_cmd_valid), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_err(wr_cmd_err),
      .wdata_valid(wdata_valid), .wdata(wdata), .wr_cmd_ready(wr_cmd_ready),
      .finish_rd(finish_rd), .finish_wr(finish_wr),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .pready(pready), .pslverr(pslverr),
      .apb_timeout(apb_timeout), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One complete transfer with the given wait states and slave error.
   task automatic xfer(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                       input int waits, input bit slv);
      if (is_wr) begin
         wr_cmd_valid = 1'b1; wdata_valid = 1'b1; wr_cmd_addr = addr; wdata = data;
      end else begin
         rd_cmd_valid = 1'b1; rd_cmd_addr = addr;
      end
      #1;
      check("grant_rd", rd_cmd_ready, !is_wr);
      check("grant_wr", wr_cmd_ready, is_wr);
      check("grant_psel", psel, 0);
      tick();
      rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; wdata_valid = 1'b0;
      #1;
      check("setup_psel", psel, 1);
      check("setup_penable", penable, 0);
      check("setup_paddr", paddr, addr);
      check("setup_pwrite", pwrite, is_wr);
      if (is_wr) check("setup_pwdata", pwdata, data);
      for (int k = 0; k <= waits; k++) begin
         tick();
         pready  = (k == waits);
         pslverr = slv && (k == waits);
         #1;
         check("access_psel", psel, 1);
         check("access_penable", penable, 1);
         check("access_paddr", paddr, addr);
         check("access_pwrite", pwrite, is_wr);
         if (is_wr) check("access_pwdata", pwdata, data);
         check("access_no_timeout", apb_timeout, 0);
      end
      tick();
      pready = 1'b0; pslverr = 1'b0;
      if (is_wr) finish_rd = 1'b1; else finish_wr = 1'b1;
      rd_cmd_valid = 1'b1; wr_cmd_valid = 1'b1; wdata_valid = 1'b1;
      rd_cmd_addr = 32'hFFFF_FFF0; wr_cmd_addr = 32'hFFFF_FFE0;
      #1;
      check("resp_psel", psel, 0);
      check("resp_penable", penable, 0);
      check("resp_err", resp_err, slv);
      check("resp_paddr_hold", paddr, addr);
      check("resp_no_rd_grant", rd_cmd_ready, 0);
      check("resp_no_wr_grant", wr_cmd_ready, 0);
      tick();
      finish_rd = 1'b0; finish_wr = 1'b0;
      #1;
      check("resp_hold_psel", psel, 0);
      check("resp_hold_err", resp_err, slv);
      check("resp_hold_no_grant", rd_cmd_ready | wr_cmd_ready, 0);
      tick();
      if (is_wr) finish_wr = 1'b1; else finish_rd = 1'b1;
      #1;
      check("resp_fin_no_grant", rd_cmd_ready | wr_cmd_ready, 0);
      tick();
      finish_rd = 1'b0; finish_wr = 1'b0;
      rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; wdata_valid = 1'b0;
      #1;
      check("idle_err_clear", resp_err, 0);
      check("idle_psel", psel, 0);
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_ready", rd_cmd_ready | wr_cmd_ready, 0);
      check("rst_timeout", apb_timeout, 0);
      check("rst_resp_err", resp_err, 0);
      reset_n = 1'b1;
      tick();

      xfer(1'b0, 32'h0000_0100, 32'h0, 0, 1'b0);
      xfer(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 3, 1'b1);

      // Contention: last grant was write, so R,W,R,W,R,W
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h10;
      wr_cmd_valid = 1'b1; wdata_valid = 1'b1; wr_cmd_addr = 32'h20; wdata = 32'h55;
      pready = 1'b1; finish_rd = 1'b1; finish_wr = 1'b1;
      n_gr = 0;
      for (int c = 0; c < 24; c++) begin
         #1;
         if (rd_cmd_ready || wr_cmd_ready) begin
            check("arb_one_hot", rd_cmd_ready & wr_cmd_ready, 0);
            check($sformatf("arb_order%0d", n_gr), wr_cmd_ready, n_gr % 2);
            n_gr++;
         end
         tick();
         if (n_gr == 6) begin
            rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; wdata_valid = 1'b0;
         end
      end
      check("arb_count", n_gr, 6);
      pready = 1'b0; finish_rd = 1'b0; finish_wr = 1'b0;

      // Errored read: no APB cycle, RESP until finish_rd
      rd_cmd_valid = 1'b1; rd_cmd_err = 1'b1; rd_cmd_addr = 32'h80;
      #1;
      check("err_ready", rd_cmd_ready, 1);
      tick();
      rd_cmd_valid = 1'b0; rd_cmd_err = 1'b0; finish_wr = 1'b1;
      #1;
      check("err_psel0", psel, 0);
      tick();
      finish_wr = 1'b0; rd_cmd_valid = 1'b1;
      #1;
      check("err_psel1", psel, 0);
      check("err_no_grant", rd_cmd_ready, 0);
      rd_cmd_valid = 1'b0;
      tick();
      finish_rd = 1'b1;
      #1;
      check("err_psel2", psel, 0);
      tick();
      finish_rd = 1'b0;

      // Write without data loses to read even though read won last time
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h180;
      wr_cmd_valid = 1'b1; wdata_valid = 1'b0; wr_cmd_addr = 32'h1C0;
      #1;
      check("nodata_rd_ready", rd_cmd_ready, 1);
      check("nodata_wr_ready", wr_cmd_ready, 0);
      tick();
      rd_cmd_valid = 1'b0; pready = 1'b1;
      #1;
      check("nodata_setup_pwrite", pwrite, 0);
      check("nodata_setup_wr", wr_cmd_ready, 0);
      tick();
      #1;
      check("nodata_access_wr", wr_cmd_ready, 0);
      tick();
      pready = 1'b0; finish_rd = 1'b1;
      #1;
      check("nodata_resp_wr", wr_cmd_ready, 0);
      tick();
      finish_rd = 1'b0;
      #1;
      check("nodata_idle_wr", wr_cmd_ready, 0);
      check("nodata_idle_psel", psel, 0);
      tick();
      #1;
      check("nodata_idle2_wr", wr_cmd_ready, 0);
      wr_cmd_valid = 1'b0;

      // Timeout: pready held low for 4 ACCESS cycles
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h200;
      #1;
      check("to_grant", rd_cmd_ready, 1);
      tick();
      rd_cmd_valid = 1'b0;
      #1;
      check("to_setup", penable, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         check("to_psel", psel, 1);
         check("to_penable", penable, 1);
         check($sformatf("to_pulse%0d", k), apb_timeout, (k == 3));
      end
      tick();
      #1;
      check("to_psel_drop", psel, 0);
      check("to_penable_drop", penable, 0);
      check("to_pulse_once", apb_timeout, 0);
      check("to_resp_err", resp_err, 1);
      finish_rd = 1'b1;
      tick();
      finish_rd = 1'b0;
      #1;
      check("to_err_clear", resp_err, 0);

      // pready on the would-be timeout cycle wins
      xfer(1'b0, 32'h0000_0300, 32'h0, 3, 1'b0);

      // Reset during ACCESS
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h400;
      #1;
      check("rst_mid_grant", rd_cmd_ready, 1);
      tick();
      rd_cmd_valid = 1'b0;
      tick();
      #1;
      check("rst_mid_access", psel & penable, 1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_psel", psel, 0);
      check("rst_mid_penable", penable, 0);
      check("rst_mid_paddr", paddr, 0);
      #2 reset_n = 1'b1;
      tick();
      rd_cmd_valid = 1'b1; rd_cmd_addr = 32'h500;
      wr_cmd_valid = 1'b1; wdata_valid = 1'b1; wr_cmd_addr = 32'h540;
      #1;
      check("post_rst_rd_first", rd_cmd_ready, 1);
      check("post_rst_wr_wait", wr_cmd_ready, 0);
      tick();
      rd_cmd_valid = 1'b0; wr_cmd_valid = 1'b0; wdata_valid = 1'b0; pready = 1'b1;
      #1;
      check("post_rst_paddr", paddr, 32'h500);
      tick();
      #1;
      check("post_rst_penable", penable, 1);
      tick();
      pready = 1'b0; finish_rd = 1'b1;
      #1;
      check("post_rst_resp", psel, 0);
      tick();
      finish_rd = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
